// File: rtl/winner_queue_if.sv
// Winner input channel and head-of-queue output channel between the aggregator,
// the queue and the consumer.
interface winner_queue_if #(
  parameter int KEY_WIDTH  = 6,
  parameter int DATA_WIDTH = 16
);
  logic                  winner_vld;
  logic [KEY_WIDTH-1:0]  winner_key;
  logic [DATA_WIDTH-1:0] winner_data;
  logic                  out_vld;
  logic [KEY_WIDTH-1:0]  out_key;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_rdy;

  // master: aggregator/consumer side; slave: the queue itself
  modport master (
    output winner_vld, winner_key, winner_data, out_rdy,
    input  out_vld, out_key, out_data
  );
  modport slave (
    input  winner_vld, winner_key, winner_data, out_rdy,
    output out_vld, out_key, out_data
  );
endinterface

// File: rtl/winner_queue.sv
// First-word-fall-through buffer for aggregator winners, with drop counting
// because the aggregator cannot be back-pressured.
module winner_queue #(
  parameter int KEY_WIDTH  = 6,
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 4,
  parameter int AF_LEVEL   = 3,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  winner_queue_if.slave                wq,
  output logic [$clog2(DEPTH+1)-1:0]   level,
  output logic                         almost_full,
  output logic                         overflow,
  output logic [CNT_WIDTH-1:0]         drop_cnt,
  input  logic                         clr_stat
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = $clog2(DEPTH+1);

  logic [KEY_WIDTH-1:0]  key_mem_q  [DEPTH];
  logic [DATA_WIDTH-1:0] data_mem_q [DEPTH];

  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]     level_q, level_d;
  logic                 overflow_q, overflow_d;
  logic [CNT_WIDTH-1:0] drop_cnt_q, drop_cnt_d;

  logic not_empty, full, pop, push, drop;

  assign not_empty = (level_q != '0);
  assign full      = (level_q == LVL_W'(DEPTH));
  assign pop       = not_empty & wq.out_rdy;
  // a pop in the same cycle frees the slot, so a full queue still accepts
  assign push      = wq.winner_vld & (~full | pop);
  assign drop      = wq.winner_vld & full & ~pop;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;

    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);

    case ({push, pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase

    // clear first so a drop in the clearing cycle is still recorded
    if (clr_stat) begin
      overflow_d = 1'b0;
      drop_cnt_d = '0;
    end
    if (drop) begin
      overflow_d = 1'b1;
      if (drop_cnt_d != '1) drop_cnt_d = drop_cnt_d + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // storage is not reset; reads are masked while empty
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      key_mem_q[wr_ptr_q]  <= wq.winner_key;
      data_mem_q[wr_ptr_q] <= wq.winner_data;
    end
  end

  assign wq.out_vld   = not_empty;
  assign wq.out_key   = not_empty ? key_mem_q[rd_ptr_q]  : '0;
  assign wq.out_data  = not_empty ? data_mem_q[rd_ptr_q] : '0;
  assign level        = level_q;
  assign almost_full  = (level_q >= LVL_W'(AF_LEVEL));
  assign overflow     = overflow_q;
  assign drop_cnt     = drop_cnt_q;
endmodule

// File: tb/tb_winner_queue.sv
// Directed and random stimulus for winner_queue, checked every cycle against a
// queue-based reference model.
module tb_winner_queue;
  localparam int KW = 6;
  localparam int DW = 16;
  localparam int DEPTH = 4;
  localparam int AF = 3;
  localparam int CW = 2;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst;
  logic clr_stat;
  logic [2:0] level;
  logic almost_full;
  logic overflow;
  logic [CW-1:0] drop_cnt;

  winner_queue_if #(.KEY_WIDTH(KW), .DATA_WIDTH(DW)) wif ();

  winner_queue #(
    .KEY_WIDTH(KW), .DATA_WIDTH(DW), .DEPTH(DEPTH), .AF_LEVEL(AF), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst(rst), .wq(wif.slave), .level(level), .almost_full(almost_full),
    .overflow(overflow), .drop_cnt(drop_cnt), .clr_stat(clr_stat)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [KW-1:0] key;
    logic [DW-1:0] data;
  } entry_t;

  entry_t m_q[$];
  int     m_cnt = 0;
  bit     m_ovf = 1'b0;
  int     n_assert = 0;
  int     n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    entry_t h;
    h = (m_q.size() > 0) ? m_q[0] : '0;
    chk("out_vld", 32'(wif.out_vld), 32'(m_q.size() > 0));
    chk("out_key", 32'(wif.out_key), 32'(h.key));
    chk("out_data", 32'(wif.out_data), 32'(h.data));
    chk("level", 32'(level), 32'(m_q.size()));
    chk("almost_full", 32'(almost_full), 32'(m_q.size() >= AF));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("drop_cnt", 32'(drop_cnt), 32'(m_cnt));
  endtask

  // Drives one cycle, advances the model at the edge, checks 1 time unit later.
  task automatic cycle(input bit v, input logic [KW-1:0] k, input logic [DW-1:0] d,
                       input bit r, input bit c, input bit rs);
    bit popped;
    wif.winner_vld  = v;
    wif.winner_key  = k;
    wif.winner_data = d;
    wif.out_rdy     = r;
    clr_stat        = c;
    rst             = rs;
    @(posedge clk);
    if (rs) begin
      m_q.delete();
      m_cnt = 0;
      m_ovf = 1'b0;
    end else begin
      popped = (m_q.size() > 0) && r;
      if (popped) void'(m_q.pop_front());
      if (c) begin
        m_cnt = 0;
        m_ovf = 1'b0;
      end
      if (v) begin
        if (m_q.size() < DEPTH) m_q.push_back({k, d});
        else begin
          m_ovf = 1'b1;
          if (m_cnt < CNT_MAX) m_cnt++;
        end
      end
    end
    #1;
    check_all();
  endtask

  initial begin
    wif.winner_vld = 0; wif.winner_key = '0; wif.winner_data = '0;
    wif.out_rdy = 0; clr_stat = 0; rst = 1;

    cycle(0, 0, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 0, 1);
    chk("reset_level", 32'(level), 0);

    // pass-through
    cycle(1, 6'h15, 16'hBEEF, 1, 0, 0);
    chk("pt_key", 32'(wif.out_key), 32'h15);
    chk("pt_data", 32'(wif.out_data), 32'hBEEF);
    cycle(0, 0, 0, 1, 0, 0);
    chk("pt_empty", 32'(wif.out_vld), 0);

    // fill and overflow, then drain 1..4
    for (int k = 1; k <= 6; k++) begin
      cycle(1, KW'(k), DW'(k * 16'h111), 0, 0, 0);
      if (k == 3) chk("af_after_3", 32'(almost_full), 1);
    end
    chk("fill_drops", 32'(drop_cnt), 2);
    chk("fill_ovf", 32'(overflow), 1);
    for (int k = 1; k <= 4; k++) begin
      chk("drain_order", 32'(wif.out_key), 32'(k));
      cycle(0, 0, 0, 1, 0, 0);
    end

    // full with simultaneous push/pop
    for (int k = 1; k <= 4; k++) cycle(1, KW'(k), DW'(k), 0, 0, 0);
    cycle(1, 6'd9, 16'h0009, 1, 0, 0);
    chk("pp_level", 32'(level), 4);
    chk("pp_drops", 32'(drop_cnt), 2);
    for (int i = 0; i < 4; i++) begin
      chk("pp_order", 32'(wif.out_key), (i == 3) ? 32'd9 : 32'(i + 2));
      cycle(0, 0, 0, 1, 0, 0);
    end

    // stall stability
    cycle(1, 6'h0A, 16'h00AA, 0, 0, 0);
    cycle(1, 6'h0B, 16'h00BB, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      cycle(0, 0, 0, 0, 0, 0);
      chk("stall_key", 32'(wif.out_key), 32'h0A);
    end
    cycle(0, 0, 0, 1, 0, 0);
    chk("stall_next", 32'(wif.out_key), 32'h0B);
    cycle(0, 0, 0, 1, 0, 0);

    // statistics: saturation and clear interactions
    cycle(0, 0, 0, 0, 1, 0);
    chk("clr_cnt", 32'(drop_cnt), 0);
    for (int k = 0; k < 9; k++) cycle(1, KW'(k + 32), DW'(k), 0, 0, 0);
    chk("sat_cnt", 32'(drop_cnt), 3);
    cycle(0, 0, 0, 0, 1, 0);
    chk("clr_alone_cnt", 32'(drop_cnt), 0);
    chk("clr_alone_ovf", 32'(overflow), 0);
    cycle(1, 6'h3E, 16'h1234, 0, 1, 0);
    chk("clr_drop_cnt", 32'(drop_cnt), 1);
    chk("clr_drop_ovf", 32'(overflow), 1);

    // reset mid-operation with a winner in the reset cycle
    cycle(0, 0, 0, 1, 0, 0);
    chk("pre_rst_level", 32'(level), 3);
    cycle(1, 6'h3F, 16'hDEAD, 0, 0, 1);
    chk("rst_level", 32'(level), 0);
    chk("rst_vld", 32'(wif.out_vld), 0);
    chk("rst_cnt", 32'(drop_cnt), 0);
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 1, 0, 0);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      cycle(bit'($urandom_range(0, 2) != 0), KW'($urandom), DW'($urandom),
            bit'($urandom_range(0, 2) == 0), bit'($urandom_range(0, 15) == 0),
            bit'($urandom_range(0, 63) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/winner_queue.md
Name: winner_queue

Overview:
- Sits directly downstream of the binary aggregator and buffers its per-cycle winner (vld/key/data) in a small first-word-fall-through FIFO.
- Presents the buffered winners to the consumer on a valid/ready handshake.
- The aggregator has no backpressure, so this block counts and flags winners dropped on overflow.
- Exports occupancy and almost_full so upstream candidate generation can throttle.

Parameters:
- KEY_WIDTH, 6, width of winner_key / out_key; must match the aggregator.
- DATA_WIDTH, 16, width of winner_data / out_data; must match the aggregator.
- DEPTH, 4, FIFO entries; power of two, >= 2.
- AF_LEVEL, 3, almost_full asserts when level >= AF_LEVEL; 1..DEPTH.
- CNT_WIDTH, 8, width of the drop counter.

Ports:
- clk  input  1  single clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- winner_vld  input  1  aggregator winner valid; no ready is returned.
- winner_key  input  KEY_WIDTH  winner key.
- winner_data  input  DATA_WIDTH  winner data.
- out_vld  output  1  head entry valid.
- out_key  output  KEY_WIDTH  head entry key.
- out_data  output  DATA_WIDTH  head entry data.
- out_rdy  input  1  consumer accepts head when out_vld & out_rdy.
- level  output  $clog2(DEPTH+1)  current entry count.
- almost_full  output  1  level >= AF_LEVEL.
- overflow  output  1  sticky: a winner was dropped since reset or the last clr_stat.
- drop_cnt  output  CNT_WIDTH  saturating count of dropped winners.
- clr_stat  input  1  clears overflow and drop_cnt.

Behaviour:
- Reset: clk and rst are the only clock and reset. Synchronous, active-high; the reset is decided as fixed.
  - Sampled high at a rising edge, rst empties the FIFO: wr_ptr = rd_ptr = 0, level = 0.
  - It also clears overflow and drop_cnt.
  - Outputs after reset: out_vld=0, out_key=0, out_data=0, level=0, almost_full=0, overflow=0, drop_cnt=0.
  - Reset mid-operation discards all entries. Winners presented in the reset cycle are not stored.
- Pop: pop = out_vld & out_rdy. out_rdy is ignored when out_vld=0.
- Push: push = winner_vld & (level < DEPTH | pop).
  - When full, a simultaneous pop frees space, so the push succeeds.
- Drop: drop = winner_vld & level == DEPTH & ~pop.
  - The entry is discarded and FIFO contents are unchanged.
- Pointers: log2(DEPTH)-bit, wrapping modulo DEPTH.
  - level updates +1 on push only, -1 on pop only, unchanged on both or neither.
  - level, almost_full and out_vld are registered/derived from registered state; they reflect the update the cycle after the event.
- Latency and ordering:
  - A winner pushed at edge N is visible on out_* after edge N, i.e. in cycle N+1, if the FIFO was empty.
  - There is no combinational bypass from winner_* to out_*.
  - Strict FIFO order, no reordering.
- Output fields: out_key/out_data equal the head entry while out_vld=1, and read as 0 while out_vld=0. Head fields stay stable while out_vld=1 & out_rdy=0.
- Statistics:
  - drop_cnt increments by 1 on each drop and saturates at 2^CNT_WIDTH-1.
  - overflow is set on any drop.
  - clr_stat with a drop in the same cycle gives drop_cnt=1, overflow=1.
  - clr_stat alone gives 0/0.
  - rst has priority over everything.
- Hazards: no X propagation. The storage array need not be reset, but out_* must be masked to 0 when empty.

Test Plan:
- Basic pass-through: rst 2 cycles, then winner_vld=1, key=0x15, data=0xBEEF for one cycle, out_rdy=1 -> cycle+1 out_vld=1, out_key=0x15, out_data=0xBEEF, level=1; next cycle out_vld=0, level=0, out_key/out_data=0.
- Fill and overflow (DEPTH=4, AF_LEVEL=3): out_rdy=0, push keys 1..6 on consecutive cycles:
  - almost_full rises the cycle after key 3 is pushed.
  - level saturates at 4.
  - Keys 5 and 6 are dropped: drop_cnt=2, overflow=1.
  - Draining then yields keys 1,2,3,4 in order.
- Full with simultaneous push/pop: FIFO holds keys 1..4, out_rdy=1 and winner key 9 in the same cycle -> no drop, level stays 4; subsequent drain order is 2,3,4,9.
- Stall stability: 2 entries (keys 0x0A, 0x0B), out_rdy=0 for 5 cycles -> out_key held at 0x0A all 5 cycles; assert out_rdy -> 0x0A, then 0x0B, on consecutive cycles.
- Statistics: with CNT_WIDTH=2, force 5 drops -> drop_cnt saturates at 3. Then:
  - clr_stat alone -> drop_cnt=0, overflow=0.
  - clr_stat together with a drop -> drop_cnt=1, overflow=1.
- Reset mid-operation: 3 entries queued and a winner arriving in the same cycle as rst=1 -> next cycle level=0, out_vld=0, drop_cnt=0; the winner from the reset cycle never appears on out_*.
